fwd_select_ctrl: RTL

//  Forwarding/hazard controller that drives the 2-bit select of the 3-input
//  16-bit ALU operand muxes: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
//  It tracks destination tags of in-flight instructions in internal EX/MEM/WB

---
 rtl/fwd_select_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fwd_select_ctrl.sv
// rtl/fwd_select_ctrl.sv - operand forwarding select and load-use stall control
module fwd_select_ctrl #(
    parameter int REG_ADDR_W     = 4,
    parameter int LOAD_STALL_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr_en,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            sel_a,
    output logic [1:0]            sel_b,
    output logic                  ex_valid
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

    // Counter preload on entering STALL; the hazard cycle itself is the first bubble.
    localparam logic [1:0] STALL_PRELOAD = 2'(LOAD_STALL_CYC - 1);
    localparam logic [REG_ADDR_W-1:0] R0 = '0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t state_q;
    logic [1:0] cnt_q;

    // Shadow pipeline. The load flag only matters while the producer sits in EX,
    // so MEM and WB carry just valid/dest/write-enable.
    logic                  ex_v_q, ex_we_q, ex_ld_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  mem_v_q, mem_we_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  wb_v_q, wb_we_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;

    logic [1:0] sel_a_q, sel_b_q;

    logic                  ex_v_d, ex_we_d, ex_ld_d;
    logic [REG_ADDR_W-1:0] ex_rd_d;
    logic [1:0]            sel_a_d, sel_b_d;

    logic hazard;
    logic ex_take;
    logic ex_fwd_ok, mem_fwd_ok, wb_wr_ok;

    // Pick the youngest producer of src. EX producers that are loads have no
    // data yet, so they are skipped here and handled by the stall instead.
    function automatic logic [1:0] sel_for(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  ex_ok,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  mem_ok,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_ok,
        input logic [REG_ADDR_W-1:0] wb_rd
    );
        if (src == R0)
            return SEL_RF;
        else if (ex_ok && ex_rd == src)
            return SEL_EXMEM;
        else if (mem_ok && mem_rd == src)
            return SEL_MEMWB;
        else if (wb_ok && wb_rd == src)
            return SEL_RF;   // write-first register file already has it
        else
            return SEL_RF;
    endfunction

    assign ex_fwd_ok  = ex_v_q  & ex_we_q  & ~ex_ld_q & (ex_rd_q  != R0);
    assign mem_fwd_ok = mem_v_q & mem_we_q & (mem_rd_q != R0);
    assign wb_wr_ok   = wb_v_q  & wb_we_q  & (wb_rd_q  != R0);

    assign hazard = id_valid & ex_v_q & ex_we_q & ex_ld_q & (ex_rd_q != R0) &
                    ((ex_rd_q == id_rs) | (ex_rd_q == id_rt));

    assign stall = ((state_q == S_IDLE) && hazard) || (state_q == S_STALL);

    // A real instruction enters EX only when decode is neither stalled nor squashed.
    assign ex_take = id_valid & ~stall & ~flush;

    // Next contents of the EX shadow slot and the selects that travel with it.
    always_comb begin
        ex_v_d  = ex_take;
        ex_rd_d = ex_take ? id_rd : R0;
        ex_we_d = ex_take & id_wr_en;
        ex_ld_d = ex_take & id_is_load;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (ex_take) begin
            sel_a_d = sel_for(id_rs, ex_fwd_ok, ex_rd_q, mem_fwd_ok, mem_rd_q, wb_wr_ok, wb_rd_q);
            sel_b_d = sel_for(id_rt, ex_fwd_ok, ex_rd_q, mem_fwd_ok, mem_rd_q, wb_wr_ok, wb_rd_q);
        end
    end

    // Advance the shadow stages and register the operand selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= R0;
            ex_we_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= R0;
            mem_we_q <= 1'b0;
            wb_v_q   <= 1'b0;
            wb_rd_q  <= R0;
            wb_we_q  <= 1'b0;
            sel_a_q  <= SEL_RF;
            sel_b_q  <= SEL_RF;
        end else begin
            ex_v_q   <= ex_v_d;
            ex_rd_q  <= ex_rd_d;
            ex_we_q  <= ex_we_d;
            ex_ld_q  <= ex_ld_d;
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_we_q <= ex_we_q;
            wb_v_q   <= mem_v_q;
            wb_rd_q  <= mem_rd_q;
            wb_we_q  <= mem_we_q;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
        end
    end

    // Stall sequencer: stretches a load-use stall to LOAD_STALL_CYC bubbles.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hazard && LOAD_STALL_CYC > 1) begin
                        state_q <= S_STALL;
                        cnt_q   <= STALL_PRELOAD;
                    end
                end
                S_STALL: begin
                    if (cnt_q <= 2'd1) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 2'd0;
                end
            endcase
        end
    end

    assign sel_a    = sel_a_q;
    assign sel_b    = sel_b_q;
    assign ex_valid = ex_v_q;

endmodule
